// File: rtl/bird_collision_fsm_if.sv
// Signal bundle between the bird/pipe movers, the game controller and the VGA overlay.
// The controller is the slave; whoever drives frame timing and positions is the master.
interface bird_collision_fsm_if;
   logic       frame_tick;
   logic       btnup;
   logic [9:0] bird_pic_t;
   logic [9:0] bird_pic_b;
   logic [9:0] pipe_l;
   logic [9:0] pipe_r;
   logic [9:0] gap_t;
   logic [9:0] gap_b;
   logic [1:0] game_state;
   logic       game_run;
   logic       game_over;
   logic       hit;
   logic [9:0] score;

   modport master (
      output frame_tick, btnup, bird_pic_t, bird_pic_b, pipe_l, pipe_r, gap_t, gap_b,
      input  game_state, game_run, game_over, hit, score
   );

   modport slave (
      input  frame_tick, btnup, bird_pic_t, bird_pic_b, pipe_l, pipe_r, gap_t, gap_b,
      output game_state, game_run, game_over, hit, score
   );
endinterface

// File: rtl/bird_collision_fsm.sv
// Game-state controller: per-frame collision check, IDLE/PLAY/DEAD sequencing and score keeping.
//
//   state | meaning
//   IDLE  | waiting for a start press; score shows last game's result
//   PLAY  | bird and pipes move; collisions and pipe passes evaluated each frame
//   DEAD  | game over; restart press accepted only after DEAD_FRAMES frames
module bird_collision_fsm #(
   parameter int unsigned MIN_Y       = 45,
   parameter int unsigned MAX_Y       = 426,
   parameter int unsigned BIRD_L      = 70,
   parameter int unsigned BIRD_W      = 25,
   parameter int unsigned DEAD_FRAMES = 60,
   parameter int unsigned SCORE_MAX   = 999
) (
   input  logic                  system_clk,
   input  logic                  rst,
   bird_collision_fsm_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(DEAD_FRAMES + 1);

   localparam logic [9:0]       MIN_Y_C     = 10'(MIN_Y);
   localparam logic [9:0]       MAX_Y_M1_C  = 10'(MAX_Y - 1);
   localparam logic [9:0]       BIRD_L_C    = 10'(BIRD_L);
   localparam logic [9:0]       BIRD_R_C    = 10'(BIRD_L + BIRD_W - 1);
   localparam logic [9:0]       SCORE_MAX_C = 10'(SCORE_MAX);
   localparam logic [CNT_W-1:0] DEAD_MAX_C  = CNT_W'(DEAD_FRAMES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_DEAD = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic [9:0]       score_q, score_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             passed_q, passed_d;
   logic             hit_q, hit_d;

   logic             sync1_q, sync2_q, sync_prev_q;
   logic             btn_rise_q;

   logic             bound_hit, x_ovl, pipe_hit, collide;

   // btnup is asynchronous: two flops, then a registered edge detect
   always_ff @(posedge system_clk) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         sync_prev_q <= 1'b0;
         btn_rise_q  <= 1'b0;
      end else begin
         sync1_q     <= bus.btnup;
         sync2_q     <= sync1_q;
         sync_prev_q <= sync2_q;
         btn_rise_q  <= sync2_q & ~sync_prev_q;
      end
   end

   // Gap edge rows are free rows, hence strict compares against the gap
   always_comb begin
      bound_hit = (bus.bird_pic_t <= MIN_Y_C) | (bus.bird_pic_b >= MAX_Y_M1_C);
      x_ovl     = (bus.pipe_l <= BIRD_R_C) & (bus.pipe_r >= BIRD_L_C);
      pipe_hit  = x_ovl & ((bus.bird_pic_t < bus.gap_t) | (bus.bird_pic_b > bus.gap_b));
      collide   = bound_hit | pipe_hit;
   end

   always_ff @(posedge system_clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         score_q  <= '0;
         cnt_q    <= '0;
         passed_q <= 1'b0;
         hit_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         score_q  <= score_d;
         cnt_q    <= cnt_d;
         passed_q <= passed_d;
         hit_q    <= hit_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      score_d  = score_q;
      cnt_d    = cnt_q;
      passed_d = passed_q;
      hit_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (btn_rise_q) begin
               state_d  = ST_PLAY;
               score_d  = '0;
               passed_d = 1'b0;
            end
         end
         ST_PLAY: begin
            if (bus.frame_tick) begin
               if (collide) begin
                  state_d = ST_DEAD;
                  hit_d   = 1'b1;
                  cnt_d   = '0;
               end else if (bus.pipe_r < BIRD_L_C) begin
                  if (!passed_q) begin
                     passed_d = 1'b1;
                     if (score_q != SCORE_MAX_C) score_d = score_q + 10'd1;
                  end
               end else begin
                  // pipe back on the right of the bird re-arms scoring
                  passed_d = 1'b0;
               end
            end
         end
         ST_DEAD: begin
            if (bus.frame_tick && (cnt_q != DEAD_MAX_C)) cnt_d = cnt_q + 1'b1;
            if ((cnt_q == DEAD_MAX_C) && btn_rise_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.game_state = state_q;
   assign bus.game_run   = (state_q == ST_PLAY);
   assign bus.game_over  = (state_q == ST_DEAD);
   assign bus.hit        = hit_q;
   assign bus.score      = score_q;

endmodule

// File: tb/tb_bird_collision_fsm.sv
// Directed scenarios plus randomized play, checked every cycle against a frame-level game model.
module tb_bird_collision_fsm;

   logic system_clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   bird_collision_fsm_if bus();

   bird_collision_fsm dut (
      .system_clk (system_clk),
      .rst        (rst),
      .bus        (bus)
   );

   always #5 system_clk = ~system_clk;

   // model: 0 IDLE, 1 PLAY, 2 DEAD
   int m_state, m_score, m_cnt;
   bit m_passed, m_hit;
   bit hist[4];  // btnup seen at the last four edges, newest first

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit collides();
      bit bnd, ovl;
      bnd = (bus.bird_pic_t <= 45) || (bus.bird_pic_b >= 425);
      ovl = (bus.pipe_l <= 94) && (bus.pipe_r >= 70);
      return bnd || (ovl && ((bus.bird_pic_t < bus.gap_t) || (bus.bird_pic_b > bus.gap_b)));
   endfunction

   task automatic model_step();
      bit rise;
      if (rst) begin
         m_state = 0; m_score = 0; m_cnt = 0; m_passed = 0; m_hit = 0;
         for (int i = 0; i < 4; i++) hist[i] = 0;
         return;
      end
      rise  = hist[2] && !hist[3];
      m_hit = 0;
      case (m_state)
         0: if (rise) begin m_state = 1; m_score = 0; m_passed = 0; end
         1: if (bus.frame_tick) begin
               if (collides()) begin
                  m_state = 2; m_hit = 1; m_cnt = 0;
               end else if (bus.pipe_r < 70) begin
                  if (!m_passed) begin
                     m_passed = 1;
                     if (m_score < 999) m_score++;
                  end
               end else m_passed = 0;
            end
         default: begin
            if (m_cnt == 60 && rise) m_state = 0;
            if (bus.frame_tick && m_cnt < 60) m_cnt++;
         end
      endcase
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = bus.btnup;
   endtask

   task automatic cycle();
      @(posedge system_clk);
      model_step();
      #1;
      chk("game_state", bus.game_state, m_state);
      chk("game_run",   bus.game_run,   m_state == 1);
      chk("game_over",  bus.game_over,  m_state == 2);
      chk("hit",        bus.hit,        m_hit);
      chk("score",      bus.score,      m_score);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic tick();
      bus.frame_tick = 1'b1;
      cycle();
      bus.frame_tick = 1'b0;
   endtask

   task automatic press();
      bus.btnup = 1'b1;
      cycles(4);
      bus.btnup = 1'b0;
      cycles(4);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   task automatic set_bird(input int t, input int b);
      bus.bird_pic_t = 10'(t);
      bus.bird_pic_b = 10'(b);
   endtask

   task automatic set_pipe(input int l, input int r, input int gt, input int gb);
      bus.pipe_l = 10'(l);
      bus.pipe_r = 10'(r);
      bus.gap_t  = 10'(gt);
      bus.gap_b  = 10'(gb);
   endtask

   task automatic restart_to_play();
      for (int i = 0; i < 61; i++) tick();
      press();
      chk("restart_idle", bus.game_state, 2'b00);
      press();
      chk("restart_play", bus.game_state, 2'b01);
   endtask

   task automatic one_pass();
      set_pipe(10, 60, 100, 400);
      tick();
      set_pipe(550, 600, 100, 400);
      tick();
   endtask

   initial begin
      int n;
      rst = 1'b1;
      bus.frame_tick = 1'b0;
      bus.btnup = 1'b0;
      set_bird(200, 218);
      set_pipe(550, 600, 100, 400);
      cycles(2);
      rst = 1'b0;
      cycle();
      chk("reset_state", bus.game_state, 2'b00);
      chk("reset_score", bus.score, 10'd0);

      // start press: visible state change 4 edges after btnup rises
      bus.btnup = 1'b1;
      n = 0;
      while (bus.game_state != 2'b01 && n < 10) begin cycle(); n++; end
      chk("start_latency", n, 4);
      bus.btnup = 1'b0;
      cycles(3);
      chk("start_run", bus.game_run, 1'b1);

      // top boundary
      set_bird(45, 63);
      tick();
      chk("bound_dead", bus.game_state, 2'b10);
      chk("bound_hit_pulse", bus.hit, 1'b1);
      cycle();
      chk("hit_one_cycle", bus.hit, 1'b0);
      restart_to_play();
      set_bird(46, 64);
      tick();
      chk("bound_ok", bus.game_state, 2'b01);

      // gap edge rows
      set_pipe(80, 130, 200, 300);
      set_bird(200, 218); tick(); chk("gap_top_edge", bus.game_state, 2'b01);
      set_bird(199, 217); tick(); chk("gap_top_hit", bus.game_state, 2'b10);
      restart_to_play();
      set_pipe(80, 130, 200, 300);
      set_bird(282, 300); tick(); chk("gap_bot_edge", bus.game_state, 2'b01);
      set_bird(283, 301); tick(); chk("gap_bot_hit", bus.game_state, 2'b10);
      restart_to_play();

      // scoring sweeps
      set_bird(200, 218);
      for (int pass = 0; pass < 2; pass++) begin
         for (int r = 75; r >= 60; r--) begin set_pipe(r - 50, r, 100, 400); tick(); end
         set_pipe(550, 600, 100, 400);
         tick();
      end
      chk("score_two", bus.score, 10'd2);
      for (int i = 0; i < 1000; i++) one_pass();
      chk("score_sat", bus.score, 10'd999);

      // dead hold-off
      set_bird(10, 28);
      tick();
      for (int i = 0; i < 10; i++) tick();
      press();
      chk("early_press", bus.game_state, 2'b10);
      for (int i = 0; i < 55; i++) tick();
      press();
      chk("late_press", bus.game_state, 2'b00);
      chk("score_held", bus.score, 10'd999);
      set_bird(200, 218);
      press();
      chk("new_game_score", bus.score, 10'd0);

      // reset mid-play
      for (int i = 0; i < 5; i++) one_pass();
      chk("score_five", bus.score, 10'd5);
      do_reset();
      chk("rst_state", bus.game_state, 2'b00);
      chk("rst_score", bus.score, 10'd0);

      // randomized play
      for (int i = 0; i < 6000; i++) begin
         int t, r, gt;
         rst = ($urandom_range(0, 799) == 0);
         bus.frame_tick = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) bus.btnup = ~bus.btnup;
         t = $urandom_range(30, 440);
         set_bird(t, t + 18);
         r = $urandom_range(0, 700);
         gt = $urandom_range(60, 300);
         set_pipe((r > 50) ? r - 50 : 0, r, gt, gt + $urandom_range(60, 150));
         cycle();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
